instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Upstream stage of the controller: owns the program counter (PC) and the instruction register (IR).
- Executes the controller's loadIR/loadPC/incPC/selA strobes against a wait-stated instruction memory.
- Presents the latched opcode and operand fields to the controller and datapath.
- Stalls the core via a busy flag while a fetch is outstanding.

Parameters:
ADDR_W, 8, PC / instruction-memory address width
DATA_W, 16, instruction width; opcode = IR[DATA_W-1:DATA_W-4]
RESET_PC, 0, PC value after reset
TIMEOUT, 15, max cycles to wait for imem_valid before aborting a fetch (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  core enable; low = synchronous abort to IDLE
loadIR  in  1  controller strobe: fetch instruction at current PC into IR
loadPC  in  1  controller strobe: PC write
incPC  in  1  controller strobe: PC <= PC+1
selA  in  1  with loadPC: PC source = jmp_addr (jump); without selA, loadPC alone does not change PC
jmp_addr  in  ADDR_W  jump target
imem_addr  out  ADDR_W  instruction memory address
imem_req  out  1  memory request, held until imem_valid
imem_valid  in  1  read data valid, single-cycle
imem_rdata  in  DATA_W  instruction word
ir  out  DATA_W  instruction register
opcode  out  4  ir[DATA_W-1:DATA_W-4], combinational from ir
operand  out  DATA_W-4  ir[DATA_W-5:0], combinational from ir
pc  out  ADDR_W  program counter
busy  out  1  fetch in progress (controller must hold its state)
fetch_err  out  1  sticky: last fetch timed out

Behaviour:
- Reset (async, rst_n low): pc=RESET_PC, ir=0, imem_req=0, imem_addr=RESET_PC, busy=0, fetch_err=0, FSM=IDLE, pending-increment=0, timeout counter=0.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - loadIR=1 and en=1 → capture imem_addr=pc, assert imem_req next cycle, busy=1, clear fetch_err, go REQ, counter=0.
- REQ:
  - imem_req=1, imem_addr stable.
  - imem_valid=1 → ir<=imem_rdata, imem_req<=0, go HOLD.
  - Otherwise counter++. Counter reaching TIMEOUT → imem_req<=0, fetch_err<=1, ir unchanged, go HOLD.
  - imem_valid in the same cycle the timeout is reached: data wins, no error.
- HOLD:
  - One cycle.
  - Applies pending increment (pc<=pc+1) if set, clears it.
  - busy<=0, go IDLE.
  - Minimum fetch latency: req asserted at cycle N+1, valid at N+1 → IR updated at N+2, busy low at N+3.
- PC update rules, evaluated every cycle with en=1:
  - loadPC & selA → pc<=jmp_addr; highest priority, applies immediately in any state, and cancels any pending increment.
  - incPC in IDLE (no jump) → pc<=pc+1.
  - incPC in REQ/HOLD → pending-increment<=1 (one deep; repeated strobes do not accumulate), applied in HOLD.
  - loadPC & selA & incPC together → jump wins, increment dropped.
  - PC arithmetic modulo 2^ADDR_W: all-ones+1 wraps to 0.
  - A jump during REQ does not alter imem_addr of the outstanding fetch.
- loadIR while busy=1: ignored (no queuing).
- en=0 (synchronous, any state):
  - imem_req<=0, busy<=0, pending cleared, counter cleared, FSM<=IDLE.
  - pc, ir and fetch_err hold.
  - imem_valid arriving after the abort is ignored.
- rst_n asserted mid-fetch: all state to reset values immediately; no IR write.
- imem_valid outside REQ: ignored.

Test Plan:
1. Reset, then pulse loadIR with memory returning 16'h4A05 after 0 wait states → imem_req high for 1 cycle at addr 0; ir=16'h4A05, opcode=4'h4, operand=12'hA05; busy high exactly 3 cycles; pc=0.
2. Memory with 3 wait states; pulse loadIR, then incPC one cycle later and again two cycles later → imem_addr=0 held 4 cycles; pc stays 0 until HOLD, then pc=1 (single increment); ir updated.
3. pc=8'h20, pulse loadPC+selA+incPC with jmp_addr=8'h7F → pc=8'h7F next cycle, no increment; next fetch uses addr 8'h7F.
4. Set pc=8'hFF via jump, pulse incPC in IDLE → pc=8'h00.
5. Memory never responds, TIMEOUT=15 → imem_req drops after 15 cycles, fetch_err=1, ir unchanged, busy low 2 cycles later; next loadIR clears fetch_err.
6. Start fetch, drop en during REQ, then assert imem_valid → imem_req=0 next cycle, busy=0, ir unchanged. Separately, assert rst_n=0 mid-REQ → all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/imem_if.sv
// imem_if: request/valid handshake between the fetch unit and instruction memory
interface imem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              req;
    logic              valid;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, output req, input valid, input rdata);
    modport slave  (input addr, input req, output valid, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns PC and IR, fetches from a wait-stated memory and stalls the core while busy
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              loadIR,
    input  logic              loadPC,
    input  logic              incPC,
    input  logic              selA,
    input  logic [ADDR_W-1:0] jmp_addr,
    imem_if.master            imem,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [DATA_W-5:0] operand,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              req_q, req_d, err_q, err_d, pend_q, pend_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              start, jump;

    assign start     = (state_q == IDLE) && loadIR && en;
    assign jump      = loadPC && selA;
    assign busy      = (state_q != IDLE) || start;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign fetch_err = err_q;
    assign opcode    = ir_q[DATA_W-1:DATA_W-4];
    assign operand   = ir_q[DATA_W-5:0];
    assign imem.addr = addr_q;
    assign imem.req  = req_q;

    // State register; async reset returns everything to power-up values mid-fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
            addr_q  <= ADDR_W'(RESET_PC);
            ir_q    <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: fetch sequencing, deferred increment while busy, jump overrides everything
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        req_d   = req_q;
        err_d   = err_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = IDLE;
            req_d   = 1'b0;
            pend_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (loadIR) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                    end
                    if (incPC) pc_d = pc_q + 1'b1;
                end
                REQ: begin
                    if (incPC) pend_d = 1'b1;
                    if (imem.valid) begin
                        ir_d    = imem.rdata;
                        req_d   = 1'b0;
                        state_d = HOLD;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (pend_q || incPC) pc_d = pc_q + 1'b1;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (jump) begin
                pc_d   = jmp_addr;
                pend_d = 1'b0;
            end
        end
    end
endmodule
